// File: rtl/sd_cmd_serial_card.sv
// Card-side SD CMD line engine.
// Receives 48-bit host command frames, validates them, presents the command
// to the card core over a four-phase REQ/ACK handshake and, when asked,
// returns a 48-bit response after an NCR-cycle turnaround gap.
// Build option: define SD_CARD_CRC_CHECK_EN to reject commands whose CRC7
// field is wrong; without it only the transmission and end bits are checked.
//
// Handshake (REQ_OUT / ACK_IN, four-phase):
//   REQ_OUT rises once a command is accepted and the synchronised ack is low.
//   CMD_OUT is valid and stable while REQ_OUT is high.
//   The core raises ACK_IN with RSP_IN/RSP_EN_IN valid. The card latches them
//   and drops REQ_OUT.
//   REQ_OUT never rises again until the synchronised ack has returned low.
module sd_cmd_serial_card #(
  parameter int NCR = 2
) (
  input  logic        SD_CLK_IN,
  input  logic        RST_N_IN,
  input  logic        cmd_dat_i,
  output logic        cmd_out_o,
  output logic        cmd_oe_o,
  output logic [37:0] CMD_OUT,
  output logic        REQ_OUT,
  input  logic        ACK_IN,
  input  logic [37:0] RSP_IN,
  input  logic        RSP_EN_IN,
  output logic        CRC_ERR_OUT,
  output logic        BUSY_OUT
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RECV  = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_REQ   = 3'd3;
  localparam logic [2:0] ST_DLY   = 3'd4;
  localparam logic [2:0] ST_SEND  = 3'd5;

  localparam logic [5:0] NCR_LAST = 6'(NCR - 1);

  logic [2:0]  state;
  logic [5:0]  bit_cnt;
  logic [5:0]  cnt_inc;
  logic [46:0] rx_sr;      // frame bits 46..0; the start bit is implicit
  logic [39:0] tx_sr;      // start, transmission and payload bits, MSB first
  logic [6:0]  crc;
  logic        crc_clr;
  logic        crc_en;
  logic        crc_bit;
  logic        crc_ok;
  logic        frame_ok;
  logic        req_q;
  logic        crc_err_q;
  logic        ack_meta;
  logic        ack_s;
  logic [2:0]  crc_idx;

  // Next-state equations of the sd_crc_7 generator (x^7 + x^3 + 1).
  function automatic logic [6:0] sd_crc_7(input logic [6:0] cur, input logic bit_val);
    logic inv;
    inv = bit_val ^ cur[6];
    return {cur[5:3], cur[2] ^ inv, cur[1:0], inv};
  endfunction

  // The counter stops at 48 instead of wrapping.
  assign cnt_inc = (bit_cnt >= 6'd48) ? 6'd48 : bit_cnt + 6'd1;

`ifdef SD_CARD_CRC_CHECK_EN
  assign crc_ok = (rx_sr[7:1] == crc);
`else
  assign crc_ok = 1'b1;
  logic unused_crc_field;
  assign unused_crc_field = ^rx_sr[7:1];
`endif

  assign frame_ok = rx_sr[46] & rx_sr[0] & crc_ok;

  // The CRC covers the first 40 frame bits. The start bit is 0 and the
  // register starts at 0, so skipping it on receive leaves the CRC unchanged.
  assign crc_clr = (state == ST_IDLE) || (state == ST_DLY);
  assign crc_en  = ((state == ST_RECV) || (state == ST_SEND)) && (bit_cnt < 6'd40);
  assign crc_bit = (state == ST_SEND) ? tx_sr[39] : cmd_dat_i;

  assign REQ_OUT     = req_q;
  assign CRC_ERR_OUT = crc_err_q;
  assign BUSY_OUT    = (state != ST_IDLE);
  assign cmd_oe_o    = (state == ST_SEND);

  // Two-flop synchroniser for the asynchronous acknowledge.
  always_ff @(posedge SD_CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= ACK_IN;
      ack_s    <= ack_meta;
    end
  end

  // Shared CRC7 register, used for receive checking and response generation.
  always_ff @(posedge SD_CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      crc <= 7'd0;
    end else if (crc_clr) begin
      crc <= 7'd0;
    end else if (crc_en) begin
      crc <= sd_crc_7(crc, crc_bit);
    end
  end

  // Command and response sequencing: receive, check, handshake, delay, send.
  always_ff @(posedge SD_CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      state     <= ST_IDLE;
      bit_cnt   <= 6'd0;
      rx_sr     <= 47'd0;
      tx_sr     <= 40'd0;
      CMD_OUT   <= 38'd0;
      req_q     <= 1'b0;
      crc_err_q <= 1'b0;
    end else begin
      crc_err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!cmd_dat_i) begin
            state   <= ST_RECV;
            bit_cnt <= 6'd1;
          end
        end
        ST_RECV: begin
          rx_sr   <= {rx_sr[45:0], cmd_dat_i};
          bit_cnt <= cnt_inc;
          if (bit_cnt == 6'd47) begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (frame_ok) begin
            CMD_OUT <= rx_sr[45:8];
            // An ack still high from the previous exchange holds REQ_OUT off.
            req_q   <= ~ack_s;
            state   <= ST_REQ;
          end else begin
            crc_err_q <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (req_q && ack_s) begin
            req_q   <= 1'b0;
            tx_sr   <= {2'b00, RSP_IN};
            bit_cnt <= 6'd0;
            state   <= RSP_EN_IN ? ST_DLY : ST_IDLE;
          end else if (!ack_s) begin
            req_q <= 1'b1;
          end
        end
        ST_DLY: begin
          if (bit_cnt == NCR_LAST) begin
            bit_cnt <= 6'd0;
            state   <= ST_SEND;
          end else begin
            bit_cnt <= cnt_inc;
          end
        end
        ST_SEND: begin
          tx_sr   <= {tx_sr[38:0], 1'b0};
          bit_cnt <= cnt_inc;
          if (bit_cnt == 6'd47) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Response bit mux: payload bits, then the CRC MSB first, then the end bit.
  always_comb begin
    cmd_out_o = 1'b1;
    crc_idx   = 3'd0;
    if (state == ST_SEND) begin
      if (bit_cnt < 6'd40) begin
        cmd_out_o = tx_sr[39];
      end else if (bit_cnt < 6'd47) begin
        crc_idx   = 3'(6'd46 - bit_cnt);
        cmd_out_o = crc[crc_idx];
      end else begin
        cmd_out_o = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sd_cmd_serial_card.sv
// Bench for sd_cmd_serial_card: directed frames from the card spec plus
// randomized commands, with a queue-based scoreboard and a reference CRC7
// computed by polynomial long division.
module tb_sd_cmd_serial_card;

  localparam int NCR = 2;

  logic        SD_CLK_IN;
  logic        RST_N_IN;
  logic        cmd_dat_i;
  logic        cmd_out_o;
  logic        cmd_oe_o;
  logic [37:0] CMD_OUT;
  logic        REQ_OUT;
  logic        ACK_IN;
  logic [37:0] RSP_IN;
  logic        RSP_EN_IN;
  logic        CRC_ERR_OUT;
  logic        BUSY_OUT;

  int n_tests = 0;
  int n_fail  = 0;

  logic [37:0] exp_cmd_q[$];
  logic [47:0] exp_rsp_q[$];
  logic [0:0]  exp_err_q[$];

  sd_cmd_serial_card #(.NCR(NCR)) dut (
    .SD_CLK_IN  (SD_CLK_IN),
    .RST_N_IN   (RST_N_IN),
    .cmd_dat_i  (cmd_dat_i),
    .cmd_out_o  (cmd_out_o),
    .cmd_oe_o   (cmd_oe_o),
    .CMD_OUT    (CMD_OUT),
    .REQ_OUT    (REQ_OUT),
    .ACK_IN     (ACK_IN),
    .RSP_IN     (RSP_IN),
    .RSP_EN_IN  (RSP_EN_IN),
    .CRC_ERR_OUT(CRC_ERR_OUT),
    .BUSY_OUT   (BUSY_OUT)
  );

  // Clock and watchdog.
  initial begin
    SD_CLK_IN = 1'b0;
    forever #5 SD_CLK_IN = ~SD_CLK_IN;
  end

  initial begin
    #2_000_000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  // Remainder of msg(x) * x^7 divided by x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_ref(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'd0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [47:0] mk_cmd(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] m;
    m = {2'b01, idx, arg};
    return {m, crc7_ref(m), 1'b1};
  endfunction

  function automatic logic [47:0] mk_rsp(input logic [37:0] rsp);
    logic [39:0] m;
    m = {2'b00, rsp};
    return {m, crc7_ref(m), 1'b1};
  endfunction

  // Driver tasks.
  task automatic send_frame(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      @(negedge SD_CLK_IN);
      cmd_dat_i = f[i];
    end
    @(negedge SD_CLK_IN);
    cmd_dat_i = 1'b1;
  endtask

  // Called at the first negedge after the end bit was sampled (CHECK cycle).
  task automatic check_outcome(input logic acc);
    check("req_in_check", 64'(REQ_OUT), 64'(0));
    check("err_in_check", 64'(CRC_ERR_OUT), 64'(0));
    @(negedge SD_CLK_IN);
    check("req_latency", 64'(REQ_OUT), 64'(acc));
    check("err_pulse", 64'(CRC_ERR_OUT), 64'(!acc));
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (BUSY_OUT && c < 200) begin
      @(negedge SD_CLK_IN);
      c++;
    end
    if (BUSY_OUT) fail("idle_timeout");
  endtask

  task automatic handshake(input logic [37:0] rsp, input logic en, input bit push_exp,
                           input bit hold_ack, input int ack_delay);
    int c;
    c = 0;
    while (!REQ_OUT && c < 100) begin
      @(negedge SD_CLK_IN);
      c++;
    end
    if (!REQ_OUT) begin
      fail("req_timeout");
      return;
    end
    repeat (ack_delay) @(negedge SD_CLK_IN);
    RSP_IN    = rsp;
    RSP_EN_IN = en;
    ACK_IN    = 1'b1;
    if (en && push_exp) exp_rsp_q.push_back(mk_rsp(rsp));
    c = 0;
    while (REQ_OUT && c < 10) begin
      @(negedge SD_CLK_IN);
      c++;
    end
    check("ack_to_req_fall", 64'(c), 64'(3));
    check("busy_after_ack", 64'(BUSY_OUT), 64'(en));
    if (!hold_ack) ACK_IN = 1'b0;
    if (en) begin
      c = 0;
      while (!cmd_oe_o && c < 20) begin
        @(negedge SD_CLK_IN);
        c++;
      end
      check("ncr_gap", 64'(c), 64'(NCR));
    end else begin
      check("oe_no_rsp", 64'(cmd_oe_o), 64'(0));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_oe"},     64'(cmd_oe_o),    64'(0));
    check({tag, "_out"},    64'(cmd_out_o),   64'(1));
    check({tag, "_req"},    64'(REQ_OUT),     64'(0));
    check({tag, "_err"},    64'(CRC_ERR_OUT), 64'(0));
    check({tag, "_busy"},   64'(BUSY_OUT),    64'(0));
    check({tag, "_cmdout"}, 64'(CMD_OUT),     64'(0));
  endtask

  // Scoreboard monitor: pops expectations whenever the card presents output.
  logic        prev_req;
  logic [37:0] held_cmd;
  logic [47:0] rsp_buf;
  int          rsp_cnt;
  logic [0:0]  err_tag;

  initial begin
    prev_req = 1'b0;
    held_cmd = '0;
    rsp_buf  = '0;
    rsp_cnt  = 0;
  end

  always @(negedge SD_CLK_IN) begin
    if (!RST_N_IN) begin
      prev_req = 1'b0;
      rsp_cnt  = 0;
    end else begin
      if (REQ_OUT && !prev_req) begin
        if (exp_cmd_q.size() == 0) begin
          fail("unexpected_req");
        end else begin
          held_cmd = exp_cmd_q.pop_front();
          check("cmd_out", 64'(CMD_OUT), 64'(held_cmd));
        end
      end else if (REQ_OUT) begin
        check("cmd_stable", 64'(CMD_OUT), 64'(held_cmd));
      end
      prev_req = REQ_OUT;

      if (CRC_ERR_OUT) begin
        if (exp_err_q.size() == 0) begin
          fail("unexpected_crc_err");
        end else begin
          err_tag = exp_err_q.pop_front();
          check("busy_on_reject", 64'(BUSY_OUT), 64'(0));
        end
      end

      if (cmd_oe_o) begin
        rsp_buf = {rsp_buf[46:0], cmd_out_o};
        rsp_cnt++;
        if (rsp_cnt == 48) begin
          if (exp_rsp_q.size() == 0) fail("unexpected_rsp");
          else check("rsp_frame", 64'(rsp_buf), 64'(exp_rsp_q.pop_front()));
          rsp_cnt = 0;
        end
      end else if (rsp_cnt != 0) begin
        fail("rsp_truncated");
        rsp_cnt = 0;
      end
    end
  end

  // Stimulus.
  initial begin
    logic [47:0] f;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [37:0] rsp;
    logic        en;
    logic        acc;
    int          kind;
    int          b;

    cmd_dat_i = 1'b1;
    ACK_IN    = 1'b0;
    RSP_IN    = '0;
    RSP_EN_IN = 1'b0;
    RST_N_IN  = 1'b0;
    #3;
    check_reset_outputs("por");
    repeat (3) @(negedge SD_CLK_IN);
    RST_N_IN = 1'b1;
    repeat (3) @(negedge SD_CLK_IN);

    // CMD0 with correct CRC, no response.
    exp_cmd_q.push_back(38'h0);
    send_frame(48'h40_0000_0000_95);
    check_outcome(1'b1);
    handshake(38'h0, 1'b0, 1'b0, 1'b0, 1);
    wait_idle();

    // CMD17 with R1 response 0x11_00000900, CRC7 0x33.
    exp_cmd_q.push_back({6'h11, 32'h0});
    send_frame(48'h51_0000_0000_55);
    check_outcome(1'b1);
    exp_rsp_q.push_back(48'h11_0000_0900_67);
    handshake(38'h11_0000_0900, 1'b1, 1'b0, 1'b0, 2);
    wait_idle();

    // CMD0 with a corrupted CRC byte.
`ifdef SD_CARD_CRC_CHECK_EN
    exp_err_q.push_back(1'b1);
    send_frame(48'h40_0000_0000_97);
    check_outcome(1'b0);
`else
    exp_cmd_q.push_back(38'h0);
    send_frame(48'h40_0000_0000_97);
    check_outcome(1'b1);
    handshake(38'h0, 1'b0, 1'b0, 1'b0, 0);
`endif
    wait_idle();

    // Accepted command without a response: line stays released.
    exp_cmd_q.push_back({6'd55, 32'h0});
    send_frame(mk_cmd(6'd55, 32'h0));
    check_outcome(1'b1);
    handshake(38'h3F_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 0);
    repeat (4) begin
      @(negedge SD_CLK_IN);
      check("oe_idle_no_rsp", 64'(cmd_oe_o), 64'(0));
    end

    // ACK left high: reject a bad transmission bit, then hold REQ off.
    exp_cmd_q.push_back({6'd8, 32'h0000_01AA});
    send_frame(mk_cmd(6'd8, 32'h0000_01AA));
    check_outcome(1'b1);
    handshake(38'h0, 1'b0, 1'b0, 1'b1, 0);
    wait_idle();
    exp_err_q.push_back(1'b1);
    f = mk_cmd(6'd2, 32'h0);
    f[46] = 1'b0;
    send_frame(f);
    check_outcome(1'b0);
    wait_idle();
    exp_cmd_q.push_back({6'd3, 32'h0});
    send_frame(mk_cmd(6'd3, 32'h0));
    repeat (10) begin
      @(negedge SD_CLK_IN);
      check("req_held_low", 64'(REQ_OUT), 64'(0));
    end
    check("busy_while_held", 64'(BUSY_OUT), 64'(1));
    ACK_IN = 1'b0;
    handshake(38'h03_1234_0000, 1'b1, 1'b1, 1'b0, 1);
    wait_idle();

    // Reset in the middle of a response.
    exp_cmd_q.push_back({6'h11, 32'h0});
    send_frame(48'h51_0000_0000_55);
    check_outcome(1'b1);
    handshake(38'h11_0000_0900, 1'b1, 1'b0, 1'b0, 0);
    repeat (20) @(negedge SD_CLK_IN);
    #2 RST_N_IN = 1'b0;
    #1 check_reset_outputs("rst_mid_send");
    repeat (2) @(negedge SD_CLK_IN);
    RST_N_IN = 1'b1;
    repeat (2) @(negedge SD_CLK_IN);
    exp_cmd_q.push_back(38'h0);
    send_frame(48'h40_0000_0000_95);
    check_outcome(1'b1);
    handshake(38'h0, 1'b0, 1'b0, 1'b0, 0);
    wait_idle();

    // Randomized commands against the reference model.
    for (int it = 0; it < 24; it++) begin
      idx  = 6'($urandom_range(0, 63));
      arg  = $urandom();
      kind = $urandom_range(0, 5);
      f    = mk_cmd(idx, arg);
      acc  = 1'b1;
      case (kind)
        0: begin f[46] = 1'b0; acc = 1'b0; end
        1: begin f[0] = 1'b0; acc = 1'b0; end
        2: begin
          b = $urandom_range(1, 7);
          f[b] = ~f[b];
`ifdef SD_CARD_CRC_CHECK_EN
          acc = 1'b0;
`endif
        end
        default: acc = 1'b1;
      endcase
      if (acc) exp_cmd_q.push_back({idx, arg});
      else     exp_err_q.push_back(1'b1);
      repeat ($urandom_range(0, 4)) @(negedge SD_CLK_IN);
      send_frame(f);
      check_outcome(acc);
      if (acc) begin
        rsp = {6'($urandom_range(0, 63)), 32'($urandom())};
        en  = 1'($urandom_range(0, 1));
        handshake(rsp, en, 1'b1, 1'b0, $urandom_range(0, 5));
      end
      wait_idle();
    end

    repeat (5) @(negedge SD_CLK_IN);
    check("cmd_q_left", 64'(exp_cmd_q.size()), 64'(0));
    check("rsp_q_left", 64'(exp_rsp_q.size()), 64'(0));
    check("err_q_left", 64'(exp_err_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
